// File: rtl/dmem_pkg.sv
// Shared size codes, FSM states and address defaults for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MRG,
        ST_WR,
        ST_RESP
    } state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/dmem_lane_unit.sv
// Little-endian lane extraction for loads and lane merge for sub-word stores.
module dmem_lane_unit import dmem_pkg::*; (
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic [31:0] ram_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [4:0] shift;
    assign shift = {lane, 3'b000};

    always_comb begin
        load_value  = '0;
        merged_word = ram_word;
        case (size)
            SZ_WORD: begin
                load_value  = ram_word;
                merged_word = store_data;
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    load_value            = {16'h0000, ram_word[31:16]};
                    merged_word[31:16]    = store_data[15:0];
                end else begin
                    load_value            = {16'h0000, ram_word[15:0]};
                    merged_word[15:0]     = store_data[15:0];
                end
            end
            SZ_BYTE: begin
                load_value  = (ram_word >> shift) & 32'h0000_00FF;
                merged_word = (ram_word & ~(32'h0000_00FF << shift))
                            | ({24'h000000, store_data[7:0]} << shift);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory target: one request at a time, mapped onto a 1-cycle-latency word RAM
// with read-modify-write for byte/halfword stores.
module dmem_responder import dmem_pkg::*; #(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned ADDR_W    = 11
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_e      state;
    logic        we_q;
    size_e       size_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    size_e       req_size_e;
    logic [31:0] off;
    logic        req_err;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    assign req_size_e = size_e'(req_size);
    assign off        = req_addr - BASE_ADDR;

    // Offsets below the base wrap to huge values and fail the range test.
    always_comb begin
        req_err = 1'b0;
        case (req_size_e)
            SZ_ILL:  req_err = 1'b1;
            SZ_HALF: req_err = off[0];
            SZ_WORD: req_err = (off[1:0] != 2'b00);
            default: ;
        endcase
        if (off[31:ADDR_W+2] != '0)
            req_err = 1'b1;
    end

    dmem_lane_unit u_lane (
        .size        (size_q),
        .lane        (lane_q),
        .ram_word    (ram_rdata),
        .store_data  (wdata_q),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            size_q    <= SZ_WORD;
            lane_q    <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        size_q    <= req_size_e;
                        lane_q    <= off[1:0];
                        wdata_q   <= req_wdata;
                        rsp_rdata <= '0;
                        if (req_err) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            ram_en   <= 1'b1;
                            ram_addr <= off[ADDR_W+1:2];
                            if (req_we && req_size_e == SZ_WORD) begin
                                ram_we    <= 1'b1;
                                ram_wdata <= req_wdata;
                                state     <= ST_WR;
                            end else begin
                                ram_we <= 1'b0;
                                state  <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    ram_en <= 1'b0;
                    state  <= ST_MRG;
                end
                ST_MRG: begin
                    if (we_q) begin
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_wdata <= merged_word;
                        state     <= ST_WR;
                    end else begin
                        rsp_rdata <= load_value;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_WR: begin
                    ram_en    <= 1'b0;
                    ram_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a word-array reference model.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          AW    = 11;
    localparam int          WORDS = 2048;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_we;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = 32'h0;

    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk_in = ~clk_in;

    dmem_responder #(.BASE_ADDR(BASE), .ADDR_W(AW)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Single-port synchronous RAM with one cycle of read latency.
    always @(posedge clk_in) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic set_word(input int idx, input logic [31:0] val);
        mem[idx]     = val;
        ref_mem[idx] = val;
    endtask

    // Reference: byte-offset arithmetic over a word array.
    task automatic model(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                         output int lat, output int n_en, output int n_wr, output int idx);
        logic [31:0] off, word, mask;
        int b;
        off   = addr - BASE;
        err   = (size == 2'd3) || (size == 2'd1 && off % 2 != 0) ||
                (size == 2'd0 && off % 4 != 0) || (off >= 32'(4 * WORDS));
        rdata = 32'h0;
        n_wr  = 0;
        idx   = 0;
        if (err) begin
            lat  = 1;
            n_en = 0;
            return;
        end
        idx  = int'(off / 4);
        b    = int'(off % 4);
        word = ref_mem[idx];
        if (!we) begin
            lat  = 3;
            n_en = 1;
            case (size)
                2'd0:    rdata = word;
                2'd1:    rdata = (word >> (8 * b)) & 32'h0000_FFFF;
                default: rdata = (word >> (8 * b)) & 32'h0000_00FF;
            endcase
        end else begin
            n_wr = 1;
            if (size == 2'd0) begin
                lat = 2;
                n_en = 1;
                ref_mem[idx] = wdata;
            end else begin
                lat  = 4;
                n_en = 2;
                mask = (size == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF;
                mask = mask << (8 * b);
                ref_mem[idx] = (word & ~mask) | ((wdata << (8 * b)) & mask);
            end
        end
    endtask

    task automatic run_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output int n_en, output int n_wr,
                           output logic [AW-1:0] wr_addr, output logic [31:0] wr_data);
        @(negedge clk_in);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b0;
        n_en = 0;
        n_wr = 0;
        wr_addr = '0;
        wr_data = '0;
        @(posedge clk_in);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            if (ram_en) n_en++;
            if (ram_en && ram_we) begin
                n_wr++;
                wr_addr = ram_addr;
                wr_data = ram_wdata;
            end
            @(posedge clk_in);
            #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        repeat (hold) @(posedge clk_in);
        @(negedge clk_in);
        rsp_ready = 1'b1;
        @(posedge clk_in);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk_in);
        vectors++;
        if ({ram_en, ram_we, rsp_valid, rsp_err, req_ready} !== 5'b00001) begin
            $display("FAIL reset_flags: got %b expected %b", {ram_en, ram_we, rsp_valid, rsp_err, req_ready}, 5'b00001);
            miscompares++;
        end
        vectors++;
        if ({rsp_rdata, ram_wdata, ram_addr} !== '0) begin
            $display("FAIL reset_data: got rdata=%h wdata=%h addr=%h expected all zero", rsp_rdata, ram_wdata, ram_addr);
            miscompares++;
        end
        reset = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_word_store_load();
        logic err, e_err; logic [31:0] rd, e_rd, wd; logic [AW-1:0] wa;
        int lat, e_lat, n_en, e_en, n_wr, e_wr, idx;
        model(1'b1, 2'd0, BASE + 32'h8, 32'hDEAD_BEEF, e_err, e_rd, e_lat, e_en, e_wr, idx);
        run_req(1'b1, 2'd0, BASE + 32'h8, 32'hDEAD_BEEF, 0, lat, rd, err, n_en, n_wr, wa, wd);
        vectors++;
        if (lat !== 2 || err !== 1'b0 || n_wr !== 1 || wa !== 11'd2) begin
            $display("FAIL word_store: got lat=%0d err=%b writes=%0d addr=%0d expected lat=2 err=0 writes=1 addr=2", lat, err, n_wr, wa);
            miscompares++;
        end
        vectors++;
        if (mem[2] !== 32'hDEAD_BEEF) begin
            $display("FAIL word_store_mem: got %h expected %h", mem[2], 32'hDEAD_BEEF);
            miscompares++;
        end
        model(1'b0, 2'd0, BASE + 32'h8, 32'h0, e_err, e_rd, e_lat, e_en, e_wr, idx);
        run_req(1'b0, 2'd0, BASE + 32'h8, 32'h0, 0, lat, rd, err, n_en, n_wr, wa, wd);
        vectors++;
        if (lat !== 3 || rd !== 32'hDEAD_BEEF || err !== 1'b0 || n_wr !== 0) begin
            $display("FAIL word_load: got lat=%0d rdata=%h err=%b writes=%0d expected lat=3 rdata=deadbeef err=0 writes=0", lat, rd, err, n_wr);
            miscompares++;
        end
    endtask

    task automatic test_byte_merge();
        logic err, e_err; logic [31:0] rd, e_rd, wd; logic [AW-1:0] wa;
        int lat, e_lat, n_en, e_en, n_wr, e_wr, idx;
        set_word(2, 32'h1122_3344);
        model(1'b1, 2'd2, BASE + 32'hA, 32'hFFFF_FFAB, e_err, e_rd, e_lat, e_en, e_wr, idx);
        run_req(1'b1, 2'd2, BASE + 32'hA, 32'hFFFF_FFAB, 0, lat, rd, err, n_en, n_wr, wa, wd);
        vectors++;
        if (wd !== 32'h11AB_3344 || lat !== 4 || n_wr !== 1 || n_en !== 2 || rd !== 32'h0) begin
            $display("FAIL byte_store: got wdata=%h lat=%0d writes=%0d en=%0d rdata=%h expected 11ab3344 4 1 2 0", wd, lat, n_wr, n_en, rd);
            miscompares++;
        end
        vectors++;
        if (mem[2] !== ref_mem[2]) begin
            $display("FAIL byte_store_mem: got %h expected %h", mem[2], ref_mem[2]);
            miscompares++;
        end
        model(1'b0, 2'd2, BASE + 32'hA, 32'h0, e_err, e_rd, e_lat, e_en, e_wr, idx);
        run_req(1'b0, 2'd2, BASE + 32'hA, 32'h0, 0, lat, rd, err, n_en, n_wr, wa, wd);
        vectors++;
        if (rd !== 32'h0000_00AB || lat !== 3) begin
            $display("FAIL byte_load: got rdata=%h lat=%0d expected 000000ab 3", rd, lat);
            miscompares++;
        end
    endtask

    task automatic test_half_load();
        logic err, e_err; logic [31:0] rd, e_rd, wd; logic [AW-1:0] wa;
        int lat, e_lat, n_en, e_en, n_wr, e_wr, idx;
        set_word(2, 32'h8765_4321);
        model(1'b0, 2'd1, BASE + 32'hA, 32'h0, e_err, e_rd, e_lat, e_en, e_wr, idx);
        run_req(1'b0, 2'd1, BASE + 32'hA, 32'h0, 0, lat, rd, err, n_en, n_wr, wa, wd);
        vectors++;
        if (rd !== 32'h0000_8765 || err !== 1'b0) begin
            $display("FAIL half_load_hi: got rdata=%h err=%b expected 00008765 0", rd, err);
            miscompares++;
        end
        run_req(1'b0, 2'd1, BASE + 32'h8, 32'h0, 0, lat, rd, err, n_en, n_wr, wa, wd);
        vectors++;
        if (rd !== 32'h0000_4321 || err !== 1'b0) begin
            $display("FAIL half_load_lo: got rdata=%h err=%b expected 00004321 0", rd, err);
            miscompares++;
        end
    endtask

    task automatic test_errors();
        logic        t_we   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  t_size [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd2};
        logic [31:0] t_addr [6] = '{32'h1001_0002, 32'h1001_0001, 32'h1001_0000,
                                    32'h1000_FFFC, 32'h1001_2000, 32'h1001_2000};
        logic err; logic [31:0] rd, wd; logic [AW-1:0] wa;
        int lat, n_en, n_wr;
        for (int i = 0; i < 6; i++) begin
            run_req(t_we[i], t_size[i], t_addr[i], 32'hFFFF_FFFF, 0, lat, rd, err, n_en, n_wr, wa, wd);
            vectors++;
            if (err !== 1'b1 || rd !== 32'h0 || n_en !== 0 || lat !== 1) begin
                $display("FAIL error[%0d]: got err=%b rdata=%h ram_en_cycles=%0d lat=%0d expected 1 0 0 1", i, err, rd, n_en, lat);
                miscompares++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic e_err, e_err2; logic [31:0] e_rd, e_rd2;
        int e_lat, e_en, e_wr, idx, lat;
        set_word(7, $urandom);
        model(1'b0, 2'd0, BASE + 32'h1C, 32'h0, e_err, e_rd, e_lat, e_en, e_wr, idx);
        model(1'b0, 2'd2, BASE + 32'h1D, 32'h0, e_err2, e_rd2, e_lat, e_en, e_wr, idx);
        @(negedge clk_in);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_addr = BASE + 32'h1C;
        rsp_ready = 1'b0;
        @(posedge clk_in);
        #1;
        req_size = 2'd2; req_addr = BASE + 32'h1D;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk_in);
            #1;
            lat++;
        end
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({rsp_valid, rsp_err, req_ready, rsp_rdata} !== {1'b1, e_err, 1'b0, e_rd}) begin
                $display("FAIL hold[%0d]: got valid=%b err=%b ready=%b rdata=%h expected 1 %b 0 %h", c, rsp_valid, rsp_err, req_ready, rsp_rdata, e_err, e_rd);
                miscompares++;
            end
            @(posedge clk_in);
            #1;
        end
        @(negedge clk_in);
        rsp_ready = 1'b1;
        @(posedge clk_in);
        #1;
        rsp_ready = 1'b0;
        vectors++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            $display("FAIL release: got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
            miscompares++;
        end
        @(posedge clk_in);
        #1;
        req_valid = 1'b0;
        vectors++;
        if (req_ready !== 1'b0) begin
            $display("FAIL next_accept: got ready=%b expected 0", req_ready);
            miscompares++;
        end
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk_in);
            #1;
            lat++;
        end
        vectors++;
        if (rsp_rdata !== e_rd2 || lat !== 3) begin
            $display("FAIL next_load: got rdata=%h lat=%0d expected %h 3", rsp_rdata, lat, e_rd2);
            miscompares++;
        end
        @(negedge clk_in);
        rsp_ready = 1'b1;
        @(posedge clk_in);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_rmw();
        set_word(5, 32'hCAFE_F00D);
        @(negedge clk_in);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = BASE + 32'h15; req_wdata = 32'h55;
        @(posedge clk_in);
        #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk_in);
            #1;
        end
        vectors++;
        if ({ram_en, ram_we} !== 2'b11) begin
            $display("FAIL rmw_in_wr: got en=%b we=%b expected 1 1", ram_en, ram_we);
            miscompares++;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({ram_en, ram_we, req_ready, rsp_valid} !== 4'b0010) begin
            $display("FAIL rmw_reset: got en/we/ready/valid=%b expected 0010", {ram_en, ram_we, req_ready, rsp_valid});
            miscompares++;
        end
        @(negedge clk_in);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk_in);
            #1;
        end
        vectors++;
        if (mem[5] !== 32'hCAFE_F00D || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL rmw_after: got mem=%h valid=%b ready=%b expected cafef00d 0 1", mem[5], rsp_valid, req_ready);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic we, err, e_err; logic [1:0] size, lane; logic [31:0] off, wdata, rd, e_rd, wd;
        logic [AW-1:0] wa;
        int lat, e_lat, n_en, e_en, n_wr, e_wr, idx, r;
        for (int i = 0; i < 60; i++) begin
            we    = 1'($urandom_range(0, 1));
            r     = $urandom_range(0, 9);
            size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            lane  = 2'($urandom_range(0, 3));
            r     = $urandom_range(0, 9);
            if (r > 2 && size == 2'd0) lane = 2'd0;
            if (r > 2 && size == 2'd1) lane = lane & 2'b10;
            if (r == 0)      off = 32'h2000 + 32'($urandom_range(0, 255));
            else if (r == 1) off = 32'h0 - 32'($urandom_range(1, 64));
            else             off = 32'($urandom_range(0, 15) * 4) + 32'(lane);
            wdata = $urandom;
            model(we, size, BASE + off, wdata, e_err, e_rd, e_lat, e_en, e_wr, idx);
            run_req(we, size, BASE + off, wdata, $urandom_range(0, 2), lat, rd, err, n_en, n_wr, wa, wd);
            vectors++;
            if (err !== e_err || rd !== e_rd || lat !== e_lat || n_en !== e_en || n_wr !== e_wr) begin
                $display("FAIL rand[%0d]: got err=%b rdata=%h lat=%0d en=%0d wr=%0d expected %b %h %0d %0d %0d",
                         i, err, rd, lat, n_en, n_wr, e_err, e_rd, e_lat, e_en, e_wr);
                miscompares++;
            end
            if (!e_err && we) begin
                vectors++;
                if (mem[idx] !== ref_mem[idx]) begin
                    $display("FAIL rand_mem[%0d]: got %h expected %h", i, mem[idx], ref_mem[idx]);
                    miscompares++;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_word_store_load();
        test_byte_merge();
        test_half_load();
        test_errors();
        test_backpressure();
        test_reset_mid_rmw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Target side of the CPU data-memory interface. It accepts one CPU load/store request at a time over a valid/ready handshake and converts it to accesses on a single-port synchronous word RAM. The RAM has a 1-cycle read latency.
- Translates MARS data addresses by subtracting BASE_ADDR.
- Handles byte and halfword stores by read-modify-write.
- Returns loaded data right-aligned and zero-extended, plus an error flag.
- Sits between the CPU core and the word RAM inside the top-level dataflow wrapper.

Parameters:
BASE_ADDR, 32'h10010000, MARS data-segment base subtracted from req_addr
ADDR_W, 11, RAM word-address width; capacity is 2**ADDR_W words

Ports:
clk_in  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request (IDLE only)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 word, 01 halfword, 10 byte, 11 illegal
req_addr  in  32  CPU byte address (MARS space)
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  CPU accepts response
rsp_rdata  out  32  load data, right-aligned, zero-extended; 0 for stores and errors
rsp_err  out  1  misaligned, out of range, or illegal size
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write strobe (only when ram_en=1)
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  32  RAM write word
ram_rdata  in  32  RAM read word, valid the cycle after ram_en=1 with ram_we=0

Behaviour:
- Reset (asynchronous, active-high, any state): state=IDLE, all latches cleared. Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0. A request in flight is dropped with no response and no RAM write.
- Accept: req_valid & req_ready at a rising edge. Latch we, size, wdata, off = req_addr - BASE_ADDR (32-bit, wraps). req_ready=1 only in IDLE.
- Error detection, evaluated at accept:
  - err if size==11.
  - err if size==01 and off[0]=1.
  - err if size==00 and off[1:0]!=0.
  - err if off >= 4*2**ADDR_W (unsigned); addresses below BASE_ADDR therefore wrap and are rejected.
  - On error, no RAM access at all.
- States: IDLE, RD, MRG, WR, RESP.
  - IDLE -> RESP on error.
  - IDLE -> WR on word store.
  - IDLE -> RD on load or sub-word store.
  - RD: ram_en=1, ram_we=0, ram_addr=off[ADDR_W+1:2]; -> MRG.
  - MRG: capture ram_rdata.
    - Load: extract the lane into rsp_rdata; -> RESP.
    - Sub-word store: build merged word; -> WR.
  - WR: ram_en=1, ram_we=1, ram_addr as in RD, ram_wdata = word or merged word; -> RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err stable. -> IDLE when rsp_ready=1; hold otherwise.
- Lanes are little-endian.
  - Byte k = off[1:0] occupies bits 8k+7:8k.
  - Halfword: off[1]=0 -> bits 15:0, off[1]=1 -> bits 31:16.
  - Store merge replaces only the addressed lane with the low bits of wdata; other lanes are preserved.
- Latency, counted in edges from accept edge to the edge after which rsp_valid=1: error 1, word store 2, load 3, sub-word store 4.
- Back-to-back: the earliest next accept is the edge after the response handshake; there is no overlap.
- ram_en=0 in IDLE, RESP and MRG. ram_we=1 only in WR. Exactly one RAM write per successful store.
- rsp_rdata=0 on stores and errors; rsp_err=0 on success.

Decomposition:
- Shared package `dmem_pkg`:
  - size codes SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - state encoding for IDLE/RD/MRG/WR/RESP.
  - BASE_ADDR default 32'h10010000.
- One natural sub-module, `dmem_lane_unit` (combinational):
  - inputs: size, off[1:0], ram word, store data.
  - outputs: extracted load value and merged store word.
  - Shared by MRG for both the load path and the store path.

Test Plan:
- Reset mid-RMW: assert reset while in WR after sub-byte store setup -> ram_we=0 immediately, state IDLE, req_ready=1, rsp_valid=0, RAM word unchanged.
- Word store then load:
  - store 0xDEADBEEF to 0x10010008 -> ram write at ram_addr=2, rsp_valid 2 edges after accept, rsp_err=0.
  - load same address -> rsp_rdata=0xDEADBEEF after 3 edges.
- Byte store merge: RAM word 2 = 0x11223344; store byte 0xAB to 0x1001000A -> ram_wdata=0x11AB3344; a byte load of the same address returns 0x000000AB.
- Halfword load: word 2 = 0x8765_4321; load half at 0x1001000A -> rsp_rdata=0x00008765, rsp_err=0.
- Errors, each with rsp_err=1, rsp_rdata=0, ram_en never asserted, response 1 edge after accept:
  - word load at 0x10010002
  - half at 0x10010001
  - size 11
  - load at 0x1000FFFC (below base)
  - load at 0x10012000 (ADDR_W=11)
- Response backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0 throughout; after rsp_ready=1, next request accepted on the following edge.
